// File: rtl/iq_pkg.sv
// Shared decode/queue definitions: field widths, word0 bit positions, the decoded
// instruction bundle consumed by instruction_queue, and the decoder FSM states.
package iq_pkg;

  localparam int unsigned MAJOR_W = 4;
  localparam int unsigned REG_W   = 5;
  localparam int unsigned SCALE_W = 2;
  localparam int unsigned MINOR_W = 4;
  localparam int unsigned ADDR_W  = 48;
  localparam int unsigned RSVD_W  = 5;

  // Word0 field LSB positions
  localparam int unsigned MAJOR_LSB      = 28;
  localparam int unsigned SRC1_LSB       = 23;
  localparam int unsigned SRC2_LSB       = 18;
  localparam int unsigned SCALE_LSB      = 16;
  localparam int unsigned DST_LSB        = 11;
  localparam int unsigned MINOR_LSB      = 7;
  localparam int unsigned HAS_ADDR_BIT   = 6;
  localparam int unsigned OFFSET_SUB_BIT = 5;

  typedef struct packed {
    logic [MAJOR_W-1:0] major_opcode;
    logic [REG_W-1:0]   source1;
    logic [REG_W-1:0]   source2;
    logic [SCALE_W-1:0] offset_scale;
    logic [REG_W-1:0]   destination;
    logic [MINOR_W-1:0] minor_opcode;
    logic               has_address;
    logic [ADDR_W-1:0]  address;
    logic               offset_sub;
  } decoded_instr_t;

  typedef enum logic [1:0] {
    StWord0,
    StAddrLo,
    StAddrHi
  } dec_state_e;

endpackage

// File: rtl/word0_field_extract.sv
// Combinational slice of an instruction word0 into the decoded bundle, plus the
// reserved-bit legality check. Address is always zero here; the FSM fills it in.
//   word    : raw word0
//   fields  : decoded fields (address = 0)
//   illegal : reserved bits nonzero while CHECK_RESERVED is set
module word0_field_extract
  import iq_pkg::*;
#(
  parameter bit CHECK_RESERVED = 1'b1
) (
  input  logic [31:0]    word,
  output decoded_instr_t fields,
  output logic           illegal
);

  always_comb begin
    fields              = '0;
    fields.major_opcode = word[MAJOR_LSB +: MAJOR_W];
    fields.source1      = word[SRC1_LSB +: REG_W];
    fields.source2      = word[SRC2_LSB +: REG_W];
    fields.offset_scale = word[SCALE_LSB +: SCALE_W];
    fields.destination  = word[DST_LSB +: REG_W];
    fields.minor_opcode = word[MINOR_LSB +: MINOR_W];
    fields.has_address  = word[HAS_ADDR_BIT];
    fields.offset_sub   = word[OFFSET_SUB_BIT];
    illegal             = CHECK_RESERVED && (word[RSVD_W-1:0] != '0);
  end

endmodule

// File: rtl/instruction_decoder.sv
// Decode stage feeding instruction_queue. Collects word0 and, when HasAddress is
// set, two address words, then presents the decoded bundle in a single registered
// output slot that honours the queue's stall.
//   clk, reset (sync, active-high)
//   fetch_word_in/fetch_valid_in/fetch_ready_out : fetch handshake
//   flush_in  : drop partial instruction and output slot
//   stall_in  : backpressure from the queue
//   valid_out + *_out fields : decoded bundle; illegal_out pulses on rejected word0
module instruction_decoder #(
  parameter bit          CHECK_RESERVED = 1'b1,
  parameter int unsigned ADDR_W         = 48
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       fetch_word_in,
  input  logic              fetch_valid_in,
  output logic              fetch_ready_out,
  input  logic              flush_in,
  input  logic              stall_in,
  output logic              valid_out,
  output logic [3:0]        MajorOpcode_out,
  output logic [4:0]        Source1_out,
  output logic [4:0]        Source2_out,
  output logic [1:0]        OffsetScale_out,
  output logic [4:0]        Destination_out,
  output logic [3:0]        MinorOpcode_out,
  output logic              HasAddress_out,
  output logic [ADDR_W-1:0] Address_out,
  output logic              OffsetSub_out,
  output logic              illegal_out
);
  import iq_pkg::*;

  decoded_instr_t w0_fields;
  logic           w0_illegal;
  decoded_instr_t stage_q;
  decoded_instr_t slot_q;
  dec_state_e     state_q;
  logic           valid_q;
  logic           illegal_q;
  logic           accept;

  word0_field_extract #(
    .CHECK_RESERVED(CHECK_RESERVED)
  ) u_extract (
    .word   (fetch_word_in),
    .fields (w0_fields),
    .illegal(w0_illegal)
  );

  // Ready only when the slot can take a new load this cycle (empty or draining).
  assign fetch_ready_out = !reset && !flush_in && (!valid_q || !stall_in);
  assign accept          = fetch_valid_in && fetch_ready_out;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StWord0;
      valid_q   <= 1'b0;
      illegal_q <= 1'b0;
      stage_q   <= '0;
      slot_q    <= '0;
    end else if (flush_in) begin
      state_q   <= StWord0;
      valid_q   <= 1'b0;
      illegal_q <= 1'b0;
      stage_q   <= '0;
    end else begin
      illegal_q <= 1'b0;
      // Drain; a load below overrides so back-to-back loads keep valid high.
      if (!stall_in) begin
        valid_q <= 1'b0;
      end
      if (accept) begin
        unique case (state_q)
          StWord0: begin
            if (w0_illegal) begin
              illegal_q <= 1'b1;
            end else if (w0_fields.has_address) begin
              stage_q <= w0_fields;
              state_q <= StAddrLo;
            end else begin
              slot_q  <= w0_fields;
              valid_q <= 1'b1;
            end
          end
          StAddrLo: begin
            stage_q.address[31:0] <= fetch_word_in;
            state_q               <= StAddrHi;
          end
          StAddrHi: begin
            slot_q                       <= stage_q;
            slot_q.address[ADDR_W-1:32] <= fetch_word_in[15:0];
            valid_q                      <= 1'b1;
            state_q                      <= StWord0;
          end
          default: state_q <= StWord0;
        endcase
      end
    end
  end

  assign valid_out       = valid_q;
  assign illegal_out     = illegal_q;
  assign MajorOpcode_out = slot_q.major_opcode;
  assign Source1_out     = slot_q.source1;
  assign Source2_out     = slot_q.source2;
  assign OffsetScale_out = slot_q.offset_scale;
  assign Destination_out = slot_q.destination;
  assign MinorOpcode_out = slot_q.minor_opcode;
  assign HasAddress_out  = slot_q.has_address;
  assign Address_out     = slot_q.address;
  assign OffsetSub_out   = slot_q.offset_sub;

endmodule

// File: tb/tb_instruction_decoder.sv
// Bench for instruction_decoder: randomized and directed stimulus against a
// word-collecting reference model.
module tb_instruction_decoder;

  logic        clk = 1'b0;
  logic        reset, fetch_valid_in, flush_in, stall_in;
  logic [31:0] fetch_word_in;
  logic        fetch_ready_out, valid_out, HasAddress_out, OffsetSub_out, illegal_out;
  logic [3:0]  MajorOpcode_out, MinorOpcode_out;
  logic [4:0]  Source1_out, Source2_out, Destination_out;
  logic [1:0]  OffsetScale_out;
  logic [47:0] Address_out;

  always #5 clk = ~clk;

  instruction_decoder dut (
    .clk            (clk),
    .reset          (reset),
    .fetch_word_in  (fetch_word_in),
    .fetch_valid_in (fetch_valid_in),
    .fetch_ready_out(fetch_ready_out),
    .flush_in       (flush_in),
    .stall_in       (stall_in),
    .valid_out      (valid_out),
    .MajorOpcode_out(MajorOpcode_out),
    .Source1_out    (Source1_out),
    .Source2_out    (Source2_out),
    .OffsetScale_out(OffsetScale_out),
    .Destination_out(Destination_out),
    .MinorOpcode_out(MinorOpcode_out),
    .HasAddress_out (HasAddress_out),
    .Address_out    (Address_out),
    .OffsetSub_out  (OffsetSub_out),
    .illegal_out    (illegal_out)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: expected registered outputs plus the words of the
  // instruction collected so far.
  logic        m_valid = 1'b0;
  logic        m_illegal = 1'b0;
  logic [74:0] m_fields = '0;
  logic [31:0] m_words[$];
  logic        exp_ready, obs_ready;

  logic [76:0] obs, expv;
  assign obs  = {valid_out, illegal_out, MajorOpcode_out, Source1_out, Source2_out,
                 OffsetScale_out, Destination_out, MinorOpcode_out, HasAddress_out,
                 Address_out, OffsetSub_out};
  assign expv = {m_valid, m_illegal, m_fields};

  function automatic logic [74:0] decode(input logic [31:0] w0, input logic [47:0] addr);
    int unsigned u;
    logic        has;
    u   = w0;
    has = 1'((u / 64) % 2);
    return {4'((u >> 28) & 15), 5'((u >> 23) & 31), 5'((u >> 18) & 31),
            2'((u >> 16) & 3), 5'((u >> 11) & 31), 4'((u >> 7) & 15), has,
            has ? addr : 48'd0, 1'((u >> 5) & 1)};
  endfunction

  function automatic logic [31:0] mk_w0(input logic has, input logic [4:0] rsvd);
    logic [31:0] w;
    w      = $urandom;
    w[6]   = has;
    w[4:0] = rsvd;
    return w;
  endfunction

  task automatic model_update(input logic r, input logic f, input logic acc,
                              input logic [31:0] w, input logic s);
    logic [31:0] w0;
    if (r) begin
      m_valid = 1'b0; m_illegal = 1'b0; m_fields = '0; m_words.delete();
    end else if (f) begin
      m_valid = 1'b0; m_illegal = 1'b0; m_words.delete();
    end else begin
      m_illegal = 1'b0;
      if (!s) m_valid = 1'b0;
      if (acc) begin
        m_words.push_back(w);
        w0 = m_words[0];
        if (m_words.size() == 1) begin
          if (w0 % 32 != 0) begin
            m_illegal = 1'b1;
            m_words.delete();
          end else if ((w0 / 64) % 2 == 0) begin
            m_fields = decode(w0, 48'd0);
            m_valid  = 1'b1;
            m_words.delete();
          end
        end else if (m_words.size() == 3) begin
          m_fields = decode(w0, {m_words[2][15:0], m_words[1]});
          m_valid  = 1'b1;
          m_words.delete();
        end
      end
    end
  endtask

  // Called at negedge; returns at the next negedge with the model advanced.
  task automatic step(input logic r, input logic f, input logic v,
                      input logic [31:0] w, input logic s);
    reset = r; flush_in = f; fetch_valid_in = v; fetch_word_in = w; stall_in = s;
    exp_ready = !r && !f && (!m_valid || !s);
    #1 obs_ready = fetch_ready_out;
    @(posedge clk);
    model_update(r, f, v && exp_ready, w, s);
    @(negedge clk);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0);
      total++;
      if (obs_ready !== 1'b0) begin
        bad++; $display("FAIL reset_ready: got %b want 0", obs_ready);
      end
      total++;
      if (obs !== 77'd0) begin
        bad++; $display("FAIL reset_outputs: got %h want 0", obs);
      end
    end
  endtask

  task automatic test_three_word();
    logic [76:0] want;
    want = {1'b1, 1'b0, 4'hA, 5'h1F, 5'h0E, 2'd3, 5'h0B, 4'h9, 1'b1, 48'd98, 1'b1};
    step(1'b0, 1'b0, 1'b1, 32'hAFBB_5CE0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 32'h0000_0062, 1'b0);
    total++;
    if (valid_out !== 1'b0) begin
      bad++; $display("FAIL three_word_early: valid got %b want 0", valid_out);
    end
    step(1'b0, 1'b0, 1'b1, 32'h0000_0000, 1'b0);
    total++;
    if (obs !== want) begin
      bad++; $display("FAIL three_word_bundle: got %h want %h", obs, want);
    end
    total++;
    if (obs !== expv) begin
      bad++; $display("FAIL three_word_model: got %h want %h", obs, expv);
    end
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    total++;
    if (valid_out !== 1'b0) begin
      bad++; $display("FAIL three_word_drain: valid got %b want 0", valid_out);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] w;
    for (int i = 0; i < 5; i++) begin
      w = mk_w0(1'b0, 5'd0);
      step(1'b0, 1'b0, 1'b1, w, 1'b0);
      total++;
      if (obs_ready !== 1'b1) begin
        bad++; $display("FAIL b2b_ready[%0d]: got %b want 1", i, obs_ready);
      end
      total++;
      if (obs !== {1'b1, 1'b0, decode(w, 48'd0)}) begin
        bad++;
        $display("FAIL b2b_bundle[%0d]: got %h want %h", i, obs, {2'b10, decode(w, 48'd0)});
      end
    end
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic test_stall();
    logic [31:0] w, w2;
    logic [76:0] snap;
    w  = mk_w0(1'b0, 5'd0);
    w2 = mk_w0(1'b0, 5'd0);
    step(1'b0, 1'b0, 1'b1, w, 1'b0);
    snap = {1'b1, 1'b0, decode(w, 48'd0)};
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 1'b1, w2, 1'b1);
      total++;
      if (obs_ready !== 1'b0) begin
        bad++; $display("FAIL stall_ready[%0d]: got %b want 0", i, obs_ready);
      end
      total++;
      if (obs !== snap) begin
        bad++; $display("FAIL stall_hold[%0d]: got %h want %h", i, obs, snap);
      end
    end
    step(1'b0, 1'b0, 1'b1, w2, 1'b0);
    total++;
    if (obs_ready !== 1'b1) begin
      bad++; $display("FAIL stall_release_ready: got %b want 1", obs_ready);
    end
    total++;
    if (obs !== {1'b1, 1'b0, decode(w2, 48'd0)}) begin
      bad++; $display("FAIL stall_release_load: got %h want %h", obs, {2'b10, decode(w2, 48'd0)});
    end
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic test_illegal();
    logic [31:0] w;
    w = mk_w0(1'b0, 5'd0);
    step(1'b0, 1'b0, 1'b1, mk_w0(1'b1, 5'h01), 1'b0);
    total++;
    if ({valid_out, illegal_out} !== 2'b01) begin
      bad++; $display("FAIL illegal_pulse: valid,illegal got %b%b want 01", valid_out, illegal_out);
    end
    step(1'b0, 1'b0, 1'b1, w, 1'b0);
    total++;
    if (obs !== {1'b1, 1'b0, decode(w, 48'd0)}) begin
      bad++; $display("FAIL illegal_next: got %h want %h", obs, {2'b10, decode(w, 48'd0)});
    end
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic test_flush();
    logic [31:0] w;
    w = mk_w0(1'b0, 5'd0);
    step(1'b0, 1'b0, 1'b1, mk_w0(1'b1, 5'd0), 1'b0);
    step(1'b0, 1'b0, 1'b1, $urandom, 1'b0);
    step(1'b0, 1'b1, 1'b1, w, 1'b0);
    total++;
    if (obs_ready !== 1'b0 || valid_out !== 1'b0) begin
      bad++; $display("FAIL flush: ready,valid got %b%b want 00", obs_ready, valid_out);
    end
    step(1'b0, 1'b0, 1'b1, w, 1'b0);
    total++;
    if (obs !== {1'b1, 1'b0, decode(w, 48'd0)}) begin
      bad++; $display("FAIL flush_next: got %h want %h", obs, {2'b10, decode(w, 48'd0)});
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] w;
    w = mk_w0(1'b0, 5'd0);
    step(1'b0, 1'b0, 1'b1, mk_w0(1'b1, 5'd0), 1'b0);
    step(1'b0, 1'b0, 1'b1, $urandom, 1'b0);
    step(1'b1, 1'b0, 1'b1, $urandom, 1'b1);
    total++;
    if (obs_ready !== 1'b0 || obs !== 77'd0) begin
      bad++; $display("FAIL reset_mid: ready %b outputs %h want 0 0", obs_ready, obs);
    end
    step(1'b0, 1'b0, 1'b1, w, 1'b0);
    total++;
    if (obs_ready !== 1'b1 || obs !== {1'b1, 1'b0, decode(w, 48'd0)}) begin
      bad++; $display("FAIL reset_mid_next: ready %b got %h want 1 %h", obs_ready, obs,
                      {2'b10, decode(w, 48'd0)});
    end
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    total++;
    if (obs !== 77'd0) begin
      bad++; $display("FAIL reset_valid_slot: got %h want 0", obs);
    end
  endtask

  task automatic test_random();
    logic        r, f, v, s;
    logic [31:0] w;
    for (int i = 0; i < 400; i++) begin
      r = ($urandom_range(0, 99) == 0);
      f = ($urandom_range(0, 39) == 0);
      v = ($urandom_range(0, 3) != 0);
      s = ($urandom_range(0, 2) == 0);
      w = mk_w0(1'($urandom_range(0, 1)),
                ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'd0);
      step(r, f, v, w, s);
      total++;
      if (obs_ready !== exp_ready) begin
        bad++; $display("FAIL rand_ready[%0d]: got %b want %b", i, obs_ready, exp_ready);
      end
      total++;
      if (obs !== expv) begin
        bad++; $display("FAIL rand_outputs[%0d]: got %h want %h", i, obs, expv);
      end
    end
  endtask

  initial begin
    reset = 1'b1; flush_in = 1'b0; fetch_valid_in = 1'b0; stall_in = 1'b0;
    fetch_word_in = '0;
    @(negedge clk);
    test_reset();
    test_three_word();
    test_back_to_back();
    test_stall();
    test_illegal();
    test_flush();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
